// File: rtl/seq_pkg.sv
// Shared types and sizes for the step sequencer: step count, index and pitch
// widths, the pattern entry layout and the run state.
package seq_pkg;
  localparam int NUM_STEPS  = 9;
  localparam int STEP_IDX_W = 4;
  localparam int PITCH_W    = 4;

  typedef struct packed {
    logic               enable;
    logic [PITCH_W-1:0] pitch;
  } pat_entry_t;

  typedef enum logic {
    STOPPED = 1'b0,
    PLAYING = 1'b1
  } seq_state_t;
endpackage

// File: rtl/seq_tick_divider.sv
// Counts enabled cycles and emits a one-cycle tick on the last cycle of every
// TICK_DIV-cycle period; clear forces the count back to the start of a period.
module seq_tick_divider #(
  parameter int TICK_DIV = 5000000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge iCLK) begin
    if (!iRST_N || clear)
      cnt <= '0;
    else if (enable)
      cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer: rotates a one-hot step register every TICK_DIV cycles
// and gates each enabled step's note for GATE_DIV cycles.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int GATE_DIV = 2500000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iRUN,
  input  logic                  iPAT_WE,
  input  logic [STEP_IDX_W-1:0] iPAT_ADDR,
  input  logic [PITCH_W:0]      iPAT_DATA,
  output logic [NUM_STEPS-1:0]  oSTEP_REG,
  output logic [STEP_IDX_W-1:0] oSTEP_IDX,
  output logic                  oSTEP_PULSE,
  output logic                  oNOTE_PLAYING,
  output logic [PITCH_W-1:0]    oNOTE_PITCH
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]      GATE_LOAD = CNT_W'(GATE_DIV - 1);
  localparam logic [NUM_STEPS-1:0]  STEP0     = {{(NUM_STEPS-1){1'b0}}, 1'b1};
  localparam logic [STEP_IDX_W-1:0] LAST_IDX  = STEP_IDX_W'(NUM_STEPS - 1);
  localparam logic [STEP_IDX_W-1:0] ADDR_LIM  = STEP_IDX_W'(NUM_STEPS);

  seq_state_t            state, state_nxt;
  pat_entry_t            pat_mem [NUM_STEPS];
  pat_entry_t            cur_entry;
  logic [CNT_W-1:0]      gate_cnt;
  logic                  tick, step_start;
  logic [STEP_IDX_W-1:0] idx_nxt;
  logic [NUM_STEPS-1:0]  reg_nxt;

  seq_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .clear  ((state != PLAYING) || !iRUN),
    .enable (state == PLAYING),
    .tick   (tick)
  );

  always_comb begin
    state_nxt  = state;
    step_start = 1'b0;
    idx_nxt    = oSTEP_IDX;
    reg_nxt    = oSTEP_REG;
    case (state)
      STOPPED: if (iRUN) begin
        state_nxt  = PLAYING;
        step_start = 1'b1;
        idx_nxt    = '0;
        reg_nxt    = STEP0;
      end
      PLAYING: if (!iRUN) begin
        state_nxt = STOPPED;
        idx_nxt   = '0;
        reg_nxt   = STEP0;
      end else if (tick) begin
        step_start = 1'b1;
        idx_nxt    = (oSTEP_IDX == LAST_IDX) ? '0 : oSTEP_IDX + 1'b1;
        reg_nxt    = {oSTEP_REG[NUM_STEPS-2:0], oSTEP_REG[NUM_STEPS-1]};
      end
      default: state_nxt = STOPPED;
    endcase
  end

  // Read before this edge's write lands, so a same-edge write only affects later visits.
  assign cur_entry = pat_mem[idx_nxt];

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state         <= STOPPED;
      oSTEP_REG     <= STEP0;
      oSTEP_IDX     <= '0;
      oSTEP_PULSE   <= 1'b0;
      oNOTE_PLAYING <= 1'b0;
      oNOTE_PITCH   <= '0;
      gate_cnt      <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pat_mem[i] <= '0;
    end else begin
      state       <= state_nxt;
      oSTEP_REG   <= reg_nxt;
      oSTEP_IDX   <= idx_nxt;
      oSTEP_PULSE <= step_start;
      if (step_start) begin
        oNOTE_PLAYING <= cur_entry.enable;
        if (cur_entry.enable) begin
          gate_cnt    <= GATE_LOAD;
          oNOTE_PITCH <= cur_entry.pitch;
        end
      end else if (state_nxt == STOPPED) begin
        oNOTE_PLAYING <= 1'b0;
        gate_cnt      <= '0;
      end else if (oNOTE_PLAYING) begin
        if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
        else                oNOTE_PLAYING <= 1'b0;
      end
      if (iPAT_WE && (iPAT_ADDR < ADDR_LIM))
        pat_mem[iPAT_ADDR] <= iPAT_DATA;
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench: two sequencers (gate 2 and gate 4, tick 4) share stimulus;
// a timestamp-based step/note model queues expected outputs for the monitor.
module tb_step_sequencer;
  localparam int TICK = 4;

  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, we = 1'b0;
  logic [3:0] addr = '0;
  logic [4:0] data = '0;

  logic [8:0] sreg0, sreg1;
  logic [3:0] idx0, idx1, pit0, pit1;
  logic       pul0, pul1, play0, play1;

  step_sequencer #(.TICK_DIV(TICK), .GATE_DIV(2)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iRUN(run), .iPAT_WE(we), .iPAT_ADDR(addr),
    .iPAT_DATA(data), .oSTEP_REG(sreg0), .oSTEP_IDX(idx0), .oSTEP_PULSE(pul0),
    .oNOTE_PLAYING(play0), .oNOTE_PITCH(pit0));

  step_sequencer #(.TICK_DIV(TICK), .GATE_DIV(TICK)) dut_long (
    .iCLK(clk), .iRST_N(rst_n), .iRUN(run), .iPAT_WE(we), .iPAT_ADDR(addr),
    .iPAT_DATA(data), .oSTEP_REG(sreg1), .oSTEP_IDX(idx1), .oSTEP_PULSE(pul1),
    .oNOTE_PLAYING(play1), .oNOTE_PITCH(pit1));

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sreg;
    logic [3:0] idx;
    logic       pulse;
    logic       play2;
    logic       play4;
    logic [3:0] pitch;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  // Model: a step lasts TICK edges from the edge it started on; a note sounds
  // while the edge count is below its end timestamp.
  bit         m_run = 0, m_pulse = 0;
  int         m_idx = 0, m_t0 = 0, m_end2 = 0, m_end4 = 0, m_ec = 0;
  logic [3:0] m_pitch = '0;
  bit         p_en  [9];
  logic [3:0] p_pit [9];

  task automatic model_edge();
    exp_t e;
    bit   start = 0;
    int   nxt = 0;
    m_pulse = 0;
    if (!rst_n) begin
      m_run = 0; m_idx = 0; m_pitch = '0; m_end2 = m_ec; m_end4 = m_ec;
      for (int i = 0; i < 9; i++) begin p_en[i] = 0; p_pit[i] = '0; end
    end else begin
      if (m_run && !run) begin
        m_run = 0; m_idx = 0; m_end2 = m_ec; m_end4 = m_ec;
      end else if (!m_run && run) begin
        start = 1; nxt = 0;
      end else if (m_run && (m_ec - m_t0 == TICK)) begin
        start = 1; nxt = (m_idx + 1) % 9;
      end
      if (start) begin
        m_run = 1; m_idx = nxt; m_t0 = m_ec; m_pulse = 1;
        if (p_en[nxt]) begin
          m_end2 = m_ec + 2; m_end4 = m_ec + TICK; m_pitch = p_pit[nxt];
        end else begin
          m_end2 = m_ec; m_end4 = m_ec;
        end
      end
      if (we && addr < 9) begin p_en[addr] = data[4]; p_pit[addr] = data[3:0]; end
    end
    e.sreg  = 9'd1 << m_idx;
    e.idx   = 4'(m_idx);
    e.pulse = m_pulse;
    e.play2 = (m_ec < m_end2);
    e.play4 = (m_ec < m_end4);
    e.pitch = m_pitch;
    q.push_back(e);
    m_ec++;
  endtask

  task automatic cyc(input bit r, input bit rn, input bit w, input logic [3:0] a,
                     input logic [4:0] d);
    rst_n = r; run = rn; we = w; addr = a; data = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("step_reg",      sreg0,        e.sreg);
        chk("step_idx",      9'(idx0),     9'(e.idx));
        chk("step_pulse",    9'(pul0),     9'(e.pulse));
        chk("note_playing",  9'(play0),    9'(e.play2));
        chk("note_pitch",    9'(pit0),     9'(e.pitch));
        chk("long_step_reg", sreg1,        e.sreg);
        chk("long_pulse",    9'(pul1),     9'(e.pulse));
        chk("long_playing",  9'(play1),    9'(e.play4));
        chk("long_pitch",    9'(pit1),     9'(e.pitch));
      end
    end
  end

  initial begin : stim
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (50) cyc(1, 0, 0, 0, 0);

    // every step enabled, pitch = index
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 4'(i), {1'b1, 4'(i)});
    repeat (9 * TICK + 6) cyc(1, 1, 0, 0, 0);

    // only steps 0 and 7, two loops
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 1, 4'(i), (i == 0) ? 5'h13 : (i == 7) ? 5'h15 : 5'h00);
    repeat (2 * 9 * TICK + 2) cyc(1, 1, 0, 0, 0);

    // adjacent steps 2 and 3 enabled
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 1, 4'(i), (i == 2 || i == 3) ? {1'b1, 4'(i + 8)} : 5'h00);
    repeat (30) cyc(1, 1, 0, 0, 0);

    // stop mid-note on step 5, then restart
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 4'd5, 5'h19);
    for (int k = 0; k < 100 && !(m_run && m_idx == 5 && m_ec - m_t0 == 1); k++)
      cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);

    // out-of-range write, then disable step 4 on the edge it starts
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 4'(i), (i == 4) ? 5'h17 : 5'h00);
    cyc(1, 0, 1, 4'd12, 5'h1F);
    for (int k = 0; k < 100 && !(m_run && m_idx == 3 && m_ec - m_t0 == TICK); k++)
      cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 4'd4, 5'h00);
    repeat (9 * TICK + 4) cyc(1, 1, 0, 0, 0);

    // randomized traffic
    repeat (400) begin
      int unsigned r;
      r = $urandom;
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) != 0),
          ((r & 3) == 0), 4'(r >> 4), 5'(r >> 8));
    end

    // reset in the middle of a gate
    cyc(1, 0, 1, 4'd0, 5'h12);
    for (int k = 0; k < 20 && !(m_ec - 1 < m_end2 && m_ec - m_t0 == 1); k++)
      cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
